// File: rtl/nibble_adder_pkg.sv
// rtl/nibble_adder_pkg.sv - shared types and constants for the nibble-serial adder
package nibble_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIB_W = 4;

    // Never returns less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// rtl/nibble_add_slice.sv - combinational 4-bit adder slice, a+b+ci -> {co,s}
module nibble_add_slice
    import nibble_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    input  logic             ci_i,
    output logic [NIB_W-1:0] s_o,
    output logic             co_o
);

    assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + (NIB_W+1)'(ci_i);

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - multi-cycle WIDTH-bit adder over one 4-bit slice
// Optional subtract mode (port sub_i) enabled by defining NIBBLE_ADDER_SUB_EN.
module nibble_serial_adder_ctrl
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef NIBBLE_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int CNT_W   = clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic               carry_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   b_cap;
    logic               cin_cap;
    logic [NIB_W-1:0]   slice_s;
    logic               slice_co;

`ifdef NIBBLE_ADDER_SUB_EN
    // Subtract as a + ~b + 1; the caller's carry-in is ignored in this mode.
    assign b_cap   = sub_i ? ~b_i : b_i;
    assign cin_cap = sub_i ? 1'b1 : cin_i;
`else
    assign b_cap   = b_i;
    assign cin_cap = cin_i;
`endif

    nibble_add_slice u_slice (
        .a_i  (a_sh_q[NIB_W-1:0]),
        .b_i  (b_sh_q[NIB_W-1:0]),
        .ci_i (carry_q),
        .s_o  (slice_s),
        .co_o (slice_co)
    );

    // Partial results collect here and only reach sum_o on the final nibble.
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                acc_d[i*NIB_W +: NIB_W] = slice_s;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_sh_q  <= a_i;
                        b_sh_q  <= b_cap;
                        carry_q <= cin_cap;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q  <= a_sh_q >> NIB_W;
                    b_sh_q  <= b_sh_q >> NIB_W;
                    carry_q <= slice_co;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    acc_q   <= acc_d;
                    if (cnt_q == LAST_CNT) begin
                        sum_q   <= acc_d;
                        cout_q  <= slice_co;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule
